// File: rtl/fact_result_buffer_if.sv
// Handshake bundle for fact_result_buffer.
//   master : producer/consumer side (drives in_valid, in_data, out_ready)
//   slave  : buffer side (drives in_ready, out_valid, out_data, count,
//            overflow, err_odd)
interface fact_result_buffer_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [AW:0]      count;
  logic             overflow;
  logic             err_odd;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, overflow, err_odd
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, overflow, err_odd
  );
endinterface

// File: rtl/fact_result_buffer.sv
// fact_result_buffer
//   Captures each factorial result (2*n!) into a DEPTH-entry FIFO and drains
//   it to a consumer over valid/ready. Flags results lost to backpressure.
// Ports:
//   clk    : single clock, all state on posedge
//   reset  : synchronous, active-high; clears pointers, count and flags
//   bus    : fact_result_buffer_if.slave
//            in_valid/in_data/in_ready  - producer side (in_ready = not full)
//            out_valid/out_data/out_ready - consumer side (out_valid = not empty)
//            count    - entries stored, 0..DEPTH
//            overflow - sticky, set when a result is refused for lack of space
//            err_odd  - sticky odd-result flag
// Configuration:
//   RESULT_CHECK_EN - when defined, odd results are rejected (never stored)
//                     and raise err_odd; otherwise err_odd is held at 0.
module fact_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic                 clk,
  input logic                 reset,
  fact_result_buffer_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          err_odd_q,  err_odd_d;

  logic full, empty, push, pop, odd_in;

`ifdef RESULT_CHECK_EN
  // 2*n! is always even, so an odd value means a corrupted result.
  assign odd_in = bus.in_valid & bus.in_data[0];
`else
  assign odd_in = 1'b0;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.err_odd   = err_odd_q;

  always_comb begin
    push       = bus.in_valid & ~full & ~odd_in;
    pop        = ~empty & bus.out_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // Fullness is judged before the same-cycle pop: no write-through when full.
    overflow_d = overflow_q | (bus.in_valid & full & ~odd_in);
`ifdef RESULT_CHECK_EN
    err_odd_d  = err_odd_q | odd_in;
`else
    err_odd_d  = 1'b0;
`endif
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_odd_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_odd_q  <= err_odd_d;
    end
  end

  // Storage is not cleared by reset; writes are suppressed while it is held.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= bus.in_data;
  end

endmodule
